// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared arbiter state type and default starvation bound
package rvc_asap_pkg;
  typedef enum logic [1:0] {ARB, LOCKED, FORCE_CORE} t_arb_state;
  localparam int STARVE_MAX_DEF = 8;
endpackage

// File: rtl/rvc_sat_cnt.sv
// rvc_sat_cnt: saturating count of consecutive cycles a port waits ungranted
module rvc_sat_cnt #(
  parameter int MAX = 8,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic         gnt,
  output logic [W-1:0] cnt
);
  // count up while waiting, hold at MAX, clear on grant or dropped request
  always_ff @(posedge clk)
    cnt <= (!rst_n || !req || gnt) ? '0 : (cnt == W'(MAX)) ? cnt : cnt + 1'b1;
endmodule

// File: rtl/rvc_mem_arb.sv
// rvc_mem_arb: two-port (core / external) single-memory arbiter with lock and anti-starvation
module rvc_mem_arb import rvc_asap_pkg::*; #(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int AW = 32
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          CoreReq,
  input  logic          CoreWrEn,
  input  logic [AW-1:0] CoreAddr,
  input  logic [31:0]   CoreWrData,
  input  logic [3:0]    CoreByteEn,
  output logic          CoreGnt,
  output logic          CoreRdVld,
  output logic [31:0]   CoreRdData,
  input  logic          ExtReq,
  input  logic          ExtWrEn,
  input  logic [AW-1:0] ExtAddr,
  input  logic [31:0]   ExtWrData,
  input  logic [3:0]    ExtByteEn,
  output logic          ExtGnt,
  output logic          ExtRdVld,
  output logic [31:0]   ExtRdData,
  input  logic          ExtLock,
  output logic          MemEn,
  output logic          MemWrEn,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemWrData,
  output logic [3:0]    MemByteEn,
  input  logic [31:0]   MemRdData
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  t_arb_state state;
  logic [CW-1:0] core_wait, ext_wait;
  logic arb_rules, ext_pri, core_gnt, ext_gnt, core_rd, ext_rd;
  assign arb_rules = state == ARB || (state == LOCKED && !ExtLock);
  assign ext_pri = ext_wait == CW'(STARVE_MAX);
  assign core_gnt = Rst && CoreReq && (arb_rules ? !(ExtReq && ext_pri) : state == FORCE_CORE);
  assign ext_gnt = Rst && ExtReq && (arb_rules ? (!CoreReq || ext_pri) : state == LOCKED);
  assign CoreGnt = core_gnt;
  assign ExtGnt = ext_gnt;
  assign MemEn = core_gnt | ext_gnt;
  assign MemWrEn = core_gnt ? CoreWrEn : ext_gnt && ExtWrEn;
  assign MemAddr = core_gnt ? CoreAddr : ext_gnt ? ExtAddr : '0;
  assign MemWrData = core_gnt ? CoreWrData : ext_gnt ? ExtWrData : '0;
  assign MemByteEn = core_gnt ? CoreByteEn : ext_gnt ? ExtByteEn : '0;
  assign CoreRdVld = Rst && core_rd;
  assign ExtRdVld = Rst && ext_rd;
  assign CoreRdData = CoreRdVld ? MemRdData : '0;
  assign ExtRdData = ExtRdVld ? MemRdData : '0;
  rvc_sat_cnt #(.MAX(STARVE_MAX), .W(CW)) u_core_wait (
    .clk(Clock), .rst_n(Rst), .req(CoreReq), .gnt(core_gnt), .cnt(core_wait)
  );
  rvc_sat_cnt #(.MAX(STARVE_MAX), .W(CW)) u_ext_wait (
    .clk(Clock), .rst_n(Rst), .req(ExtReq), .gnt(ext_gnt), .cnt(ext_wait)
  );
  // lock / forced-core state; a core that would hit its wait limit next cycle forces a core slot
  always_ff @(posedge Clock)
    if (!Rst)
      state <= ARB;
    else
      case (state)
        ARB:        state <= (ext_gnt && ExtLock) ? LOCKED : ARB;
        LOCKED:     state <= !ExtLock ? ARB :
                             (CoreReq && core_wait >= CW'(STARVE_MAX - 1)) ? FORCE_CORE : LOCKED;
        FORCE_CORE: state <= ExtLock ? LOCKED : ARB;
        default:    state <= ARB;
      endcase
  // read owner tag: read data returns one cycle after a read grant
  always_ff @(posedge Clock) begin
    core_rd <= core_gnt && !CoreWrEn;
    ext_rd <= ext_gnt && !ExtWrEn;
  end
endmodule

// File: tb/tb_rvc_mem_arb.sv
// tb_rvc_mem_arb: scoreboard bench for the core/external memory arbiter
module tb_rvc_mem_arb;
  logic Clock = 1'b0, Rst = 1'b0;
  logic CoreReq, CoreWrEn, CoreGnt, CoreRdVld;
  logic [31:0] CoreAddr, CoreWrData, CoreRdData;
  logic [3:0] CoreByteEn;
  logic ExtReq, ExtWrEn, ExtGnt, ExtRdVld, ExtLock;
  logic [31:0] ExtAddr, ExtWrData, ExtRdData;
  logic [3:0] ExtByteEn;
  logic MemEn, MemWrEn;
  logic [31:0] MemAddr, MemWrData, MemRdData;
  logic [3:0] MemByteEn;
  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {logic ext; logic [31:0] data; int due;} rd_t;
  rd_t sb[$];
  logic mh, mext;
  logic [31:0] md;

  rvc_mem_arb dut (
    .Clock(Clock), .Rst(Rst),
    .CoreReq(CoreReq), .CoreWrEn(CoreWrEn), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
    .CoreByteEn(CoreByteEn), .CoreGnt(CoreGnt), .CoreRdVld(CoreRdVld), .CoreRdData(CoreRdData),
    .ExtReq(ExtReq), .ExtWrEn(ExtWrEn), .ExtAddr(ExtAddr), .ExtWrData(ExtWrData),
    .ExtByteEn(ExtByteEn), .ExtGnt(ExtGnt), .ExtRdVld(ExtRdVld), .ExtRdData(ExtRdData),
    .ExtLock(ExtLock), .MemEn(MemEn), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemByteEn(MemByteEn), .MemRdData(MemRdData)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // memory model: read data one cycle after a read strobe, garbage otherwise
  always @(posedge Clock) MemRdData <= (MemEn && !MemWrEn) ? mdat(MemAddr) : 32'hDEAD_BEEF;

  // scoreboard: read data expected exactly in its due cycle, nothing otherwise
  always @(negedge Clock) begin
    mh = 1'b0;
    mext = 1'b0;
    md = '0;
    if (sb.size() > 0) begin
      if (sb[0].due == cyc) begin
        mh = 1'b1;
        mext = sb[0].ext;
        md = sb[0].data;
        void'(sb.pop_front());
      end
    end
    compared++;
    if ({CoreRdVld, ExtRdVld} !== {mh && !mext, mh && mext}) begin
      mismatched++;
      $display("FAIL rdvld cyc=%0d: got core/ext %b%b want %b%b", cyc, CoreRdVld, ExtRdVld, mh && !mext, mh && mext);
    end
    compared++;
    if (CoreRdData !== ((mh && !mext) ? md : 32'h0)) begin
      mismatched++;
      $display("FAIL core_rddata cyc=%0d: got %h want %h", cyc, CoreRdData, (mh && !mext) ? md : 32'h0);
    end
    compared++;
    if (ExtRdData !== ((mh && mext) ? md : 32'h0)) begin
      mismatched++;
      $display("FAIL ext_rddata cyc=%0d: got %h want %h", cyc, ExtRdData, (mh && mext) ? md : 32'h0);
    end
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic core_drive(input logic req, input logic we, input logic [31:0] a);
    CoreReq = req;
    CoreWrEn = we;
    CoreAddr = a;
    CoreWrData = a ^ 32'h1357_9BDF;
    CoreByteEn = we ? 4'b0011 : 4'hF;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [31:0] a, input logic lock);
    ExtReq = req;
    ExtWrEn = we;
    ExtAddr = a;
    ExtWrData = a ^ 32'hA0B1_C2D3;
    ExtByteEn = we ? 4'b0110 : 4'hF;
    ExtLock = lock;
  endtask

  task automatic idle();
    core_drive(1'b0, 1'b0, 32'h0);
    ext_drive(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic push_rd(input logic ext, input logic [31:0] a);
    sb.push_back('{ext, mdat(a), cyc + 1});
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    core_drive(1'b1, 1'b1, 32'h44);
    ext_drive(1'b1, 1'b1, 32'h88, 1'b1);
    repeat (3) begin
      @(negedge Clock);
      compared++;
      if ({CoreGnt, ExtGnt, MemEn, MemWrEn} !== 4'b0000) begin
        mismatched++;
        $display("FAIL reset_gnt: got %b want 0000", {CoreGnt, ExtGnt, MemEn, MemWrEn});
      end
    end
    next_cycle();
    Rst = 1'b1;
    idle();
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt, MemEn, MemWrEn, MemAddr, MemWrData, MemByteEn} !== '0) begin
      mismatched++;
      $display("FAIL idle_outputs: got gnt %b%b en %b we %b addr %h wd %h be %h want all 0",
               CoreGnt, ExtGnt, MemEn, MemWrEn, MemAddr, MemWrData, MemByteEn);
    end
  endtask

  task automatic test_core_read();
    next_cycle();
    core_drive(1'b1, 1'b0, 32'h100);
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt, MemEn, MemWrEn, MemAddr} !== {4'b1010, 32'h100}) begin
      mismatched++;
      $display("FAIL core_read_gnt: got %b addr %h want 1010 addr 100", {CoreGnt, ExtGnt, MemEn, MemWrEn}, MemAddr);
    end
    push_rd(1'b0, 32'h100);
    next_cycle();
    idle();
    @(negedge Clock);
    compared++;
    if ({CoreRdVld, ExtRdVld, CoreRdData} !== {2'b10, mdat(32'h100)}) begin
      mismatched++;
      $display("FAIL core_read_data: got vld %b%b data %h want 10 %h", CoreRdVld, ExtRdVld, CoreRdData, mdat(32'h100));
    end
  endtask

  task automatic test_write();
    next_cycle();
    core_drive(1'b1, 1'b1, 32'h104);
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt, MemEn, MemWrEn, MemAddr, MemWrData, MemByteEn} !==
        {4'b1011, 32'h104, 32'h104 ^ 32'h1357_9BDF, 4'b0011}) begin
      mismatched++;
      $display("FAIL core_write: got %b %h %h %h", {CoreGnt, ExtGnt, MemEn, MemWrEn}, MemAddr, MemWrData, MemByteEn);
    end
    next_cycle();
    core_drive(1'b0, 1'b0, 32'h0);
    ext_drive(1'b1, 1'b1, 32'h208, 1'b0);
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt, MemEn, MemWrEn, MemAddr, MemWrData, MemByteEn} !==
        {4'b0111, 32'h208, 32'h208 ^ 32'hA0B1_C2D3, 4'b0110}) begin
      mismatched++;
      $display("FAIL ext_write: got %b %h %h %h", {CoreGnt, ExtGnt, MemEn, MemWrEn}, MemAddr, MemWrData, MemByteEn);
    end
    next_cycle();
    idle();
    @(negedge Clock);
  endtask

  task automatic test_starve();
    logic [1:0] exp;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      if (k == 1) begin
        core_drive(1'b1, 1'b0, 32'h40);
        ext_drive(1'b1, 1'b0, 32'h80, 1'b0);
      end
      @(negedge Clock);
      exp = (k == 9) ? 2'b01 : 2'b10;
      compared++;
      if ({CoreGnt, ExtGnt} !== exp) begin
        mismatched++;
        $display("FAIL starve_gnt k=%0d: got %b want %b", k, {CoreGnt, ExtGnt}, exp);
      end
      push_rd(exp[0], exp[0] ? 32'h80 : 32'h40);
    end
    next_cycle();
    idle();
    @(negedge Clock);
  endtask

  task automatic test_lock();
    logic [1:0] exp;
    next_cycle();
    ext_drive(1'b1, 1'b1, 32'h200, 1'b1);
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt, MemWrEn, MemAddr} !== {3'b011, 32'h200}) begin
      mismatched++;
      $display("FAIL lock_start: got %b addr %h want 011 addr 200", {CoreGnt, ExtGnt, MemWrEn}, MemAddr);
    end
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      if (k == 1) core_drive(1'b1, 1'b0, 32'h300);
      @(negedge Clock);
      exp = (k == 9) ? 2'b10 : 2'b01;
      compared++;
      if ({CoreGnt, ExtGnt, MemAddr} !== {exp, (k == 9) ? 32'h300 : 32'h200}) begin
        mismatched++;
        $display("FAIL locked_gnt k=%0d: got %b addr %h want %b", k, {CoreGnt, ExtGnt}, MemAddr, exp);
      end
      if (k == 9) push_rd(1'b0, 32'h300);
    end
  endtask

  task automatic test_unlock();
    next_cycle();
    ExtLock = 1'b0;
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt} !== 2'b10) begin
      mismatched++;
      $display("FAIL unlock_gnt: got %b want 10", {CoreGnt, ExtGnt});
    end
    push_rd(1'b0, 32'h300);
    next_cycle();
    ExtLock = 1'b1;
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt} !== 2'b10) begin
      mismatched++;
      $display("FAIL after_unlock_arb: got %b want 10", {CoreGnt, ExtGnt});
    end
    push_rd(1'b0, 32'h300);
    next_cycle();
    idle();
    @(negedge Clock);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      core_drive(k % 2 == 0, 1'b0, 32'h10);
      ext_drive(k % 2 == 1, 1'b0, 32'h20, 1'b0);
      @(negedge Clock);
      compared++;
      if ({CoreGnt, ExtGnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        mismatched++;
        $display("FAIL alt_gnt k=%0d: got %b", k, {CoreGnt, ExtGnt});
      end
      push_rd(k % 2 == 1, (k % 2 == 1) ? 32'h20 : 32'h10);
    end
    next_cycle();
    idle();
    @(negedge Clock);
  endtask

  task automatic test_reset_abort();
    next_cycle();
    core_drive(1'b1, 1'b0, 32'h100);
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt} !== 2'b10) begin
      mismatched++;
      $display("FAIL abort_gnt: got %b want 10", {CoreGnt, ExtGnt});
    end
    next_cycle();
    Rst = 1'b0;
    @(negedge Clock);
    compared++;
    if ({CoreGnt, ExtGnt, MemEn, MemWrEn, CoreRdVld, CoreRdData} !== '0) begin
      mismatched++;
      $display("FAIL abort_in_reset: got gnt %b%b en %b vld %b data %h want 0", CoreGnt, ExtGnt, MemEn, CoreRdVld, CoreRdData);
    end
    next_cycle();
    Rst = 1'b1;
    idle();
    @(negedge Clock);
    compared++;
    if (CoreRdVld !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_after_reset: got vld %b want 0", CoreRdVld);
    end
    test_core_read();
  endtask

  initial begin
    idle();
    test_reset();
    test_core_read();
    test_write();
    test_starve();
    test_lock();
    test_unlock();
    test_back_to_back();
    test_reset_abort();
    next_cycle();
    @(negedge Clock);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rvc_mem_arb.md
RVC_MEM_ARB -- requirements
Module: rvc_mem_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8: maximum consecutive cycles a requesting port waits before it is guaranteed a slot.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port Clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  in  1  synchronous, active-low reset.
REQ-005 SHALL have port CoreReq  in  1  core data-port access request.
REQ-006 SHALL have port CoreWrEn  in  1  core write (1) or read (0).
REQ-007 SHALL have port CoreAddr  in  AW  core byte address.
REQ-008 SHALL have port CoreWrData  in  32  core store data.
REQ-009 SHALL have port CoreByteEn  in  4  core byte enables.
REQ-010 SHALL have port CoreGnt  out  1  core access accepted this cycle.
REQ-011 SHALL have port CoreRdVld  out  1  core read data valid.
REQ-012 SHALL have port CoreRdData  out  32  core read data.
REQ-013 SHALL have ports ExtReq, ExtWrEn, ExtAddr, ExtWrData, ExtByteEn, ExtGnt, ExtRdVld and ExtRdData, mirroring the core ports (direction and width), for the external loader/debug port.
REQ-014 SHALL have port ExtLock  in  1  external port requests exclusive burst ownership.
REQ-015 SHALL have port MemEn  out  1  memory access strobe.
REQ-016 SHALL have ports MemWrEn (out 1), MemAddr (out AW), MemWrData (out 32) and MemByteEn (out 4), carrying the granted port's access.
REQ-017 SHALL have port MemRdData  in  32  memory read data, valid exactly one cycle after a read strobe.

Function
REQ-018 Grant SHALL be combinational, in the same cycle as the request; Mem* SHALL carry the granted port's fields; MemEn = CoreGnt | ExtGnt; CoreGnt and ExtGnt SHALL never both be 1.
REQ-019 With no grant, MemEn and MemWrEn SHALL be 0, and MemAddr, MemWrData and MemByteEn SHALL be 0.
REQ-020 FSM states SHALL be ARB, LOCKED and FORCE_CORE; reset state is ARB.
REQ-021 In ARB, the core SHALL win when both ports request, unless ExtWait == STARVE_MAX, in which case ext wins.
REQ-022 ARB->LOCKED when ExtGnt && ExtLock; otherwise the FSM stays in ARB.
REQ-023 In LOCKED, only ext SHALL be granted (if ExtReq); a CoreReq SHALL be held off.
REQ-024 LOCKED->ARB when ExtLock = 0; that same cycle SHALL be arbitrated with ARB rules.
REQ-025 LOCKED->FORCE_CORE when CoreWait reaches STARVE_MAX.
REQ-026 In FORCE_CORE, the core SHALL be granted if CoreReq (ext held off); next state is LOCKED if ExtLock, else ARB.
REQ-027 CoreWait and ExtWait SHALL be saturating counters (width clog2(STARVE_MAX+1)): increment each cycle the port requests without grant, clear on its grant or when its request drops.
REQ-028 A read grant SHALL register an owner tag; on the next cycle, the owner's RdVld = 1 and its RdData = MemRdData, the other port's RdData = 0.
REQ-029 Writes SHALL produce no RdVld.
REQ-030 Back-to-back reads from alternating ports SHALL each return data in their own RdVld cycle (one outstanding read per cycle, no bubbles).
REQ-031 The arbiter SHALL NOT check requester stability; a requester SHALL hold its request until it sees its Gnt.

Reset
REQ-032 While Rst = 0 at a clock edge: FSM -> ARB, both counters -> 0, read tag cleared.
REQ-033 During reset, CoreRdVld and ExtRdVld SHALL be 0, RdData = 0, and Gnt, MemEn and MemWrEn SHALL be 0 (gated by Rst).
REQ-034 A read granted in the cycle before reset asserts SHALL produce no RdVld.

Structure
REQ-035 rvc_asap_pkg SHALL hold the arbiter state enum type (t_arb_state) and the default STARVE_MAX constant.
REQ-036 One sub-module, rvc_sat_cnt (saturating wait counter), SHALL be instantiated twice; all other logic is flat.

Verification
REQ-037 Core read 0x100 alone: CoreGnt = 1 and MemAddr = 0x100 in cycle N; CoreRdVld = 1 with CoreRdData = MemRdData in N+1; ExtRdVld = 0.
REQ-038 Both ports request continuously in ARB: core granted for 8 cycles, ext granted in cycle 9 (ExtWait = 8), then core again.
REQ-039 Ext write with ExtLock = 1, then CoreReq held: ext owns 8 cycles, then exactly one CoreGnt (FORCE_CORE), then ext resumes in LOCKED.
REQ-040 ExtLock drops in the same cycle CoreReq is high in LOCKED: CoreGnt = 1 that cycle, FSM -> ARB.
REQ-041 Alternating core/ext reads at 0x10/0x20 on consecutive cycles: RdVld alternates core/ext, each with correct data, no bubbles.
REQ-042 Rst = 0 asserted the cycle after a core read grant: CoreRdVld stays 0, all Gnt = 0, and a core read after reset release behaves as in REQ-037.
